// File: rtl/sweep_if.sv
// rtl/sweep_if.sv - control/status bundle between host config logic and the sweep sequencer
interface sweep_if #(
    parameter int D_WIDTH  = 8,
    parameter int DW_WIDTH = 16
);
    logic                start;
    logic                abort;
    logic                loop;
    logic [D_WIDTH-1:0]  incr_start;
    logic [D_WIDTH-1:0]  incr_stop;
    logic [D_WIDTH-1:0]  step;
    logic [DW_WIDTH-1:0] dwell;
    logic [D_WIDTH-1:0]  offset_in;
    logic                en;
    logic [D_WIDTH-1:0]  incr;
    logic [D_WIDTH-1:0]  offset;
    logic                busy;
    logic                done;

    modport master (
        output start, abort, loop, incr_start, incr_stop, step, dwell, offset_in,
        input  en, incr, offset, busy, done
    );

    modport slave (
        input  start, abort, loop, incr_start, incr_stop, step, dwell, offset_in,
        output en, incr, offset, busy, done
    );
endinterface

// File: rtl/sweep_ctrl.sv
// rtl/sweep_ctrl.sv - frequency-sweep sequencer driving sinegen en/incr/offset
module sweep_ctrl #(
    parameter int D_WIDTH  = 8,
    parameter int DW_WIDTH = 16
) (
    input  logic   clk,
    input  logic   rst,
    sweep_if.slave s
);
    typedef enum logic [1:0] {IDLE, SWEEP, HOLD, DONE} state_t;

    localparam logic [DW_WIDTH-1:0] DW_ONE = {{(DW_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [D_WIDTH-1:0]  D_ONE  = {{(D_WIDTH-1){1'b0}}, 1'b1};

    state_t              r_state, w_state_nxt;
    logic [DW_WIDTH-1:0] r_cnt, w_cnt_nxt;
    logic [DW_WIDTH-1:0] r_dwell, w_dwell_nxt;
    logic [D_WIDTH-1:0]  r_step, w_step_nxt;
    logic [D_WIDTH-1:0]  r_lo_start, w_lo_start_nxt;
    logic [D_WIDTH-1:0]  r_lo_stop, w_lo_stop_nxt;
    logic                r_tgt_stop, w_tgt_stop_nxt;
    logic                r_dir_dn, w_dir_dn_nxt;
    logic [D_WIDTH-1:0]  r_incr, w_incr_nxt;
    logic [D_WIDTH-1:0]  r_offset, w_offset_nxt;
    logic                r_en, r_busy, r_done;

    logic [D_WIDTH-1:0]  w_tgt, w_tgt_rev;
    logic [D_WIDTH:0]    w_fwd, w_rev;
    logic                w_last;

    // Returns {reached, value}; arithmetic is one bit wider so overflow/borrow clamp to the target.
    function automatic logic [D_WIDTH:0] step_toward(
        input logic [D_WIDTH-1:0] cur,
        input logic               dn,
        input logic [D_WIDTH-1:0] stp,
        input logic [D_WIDTH-1:0] tgt
    );
        logic [D_WIDTH:0] n;
        logic             reached;
        if (dn) begin
            n       = {1'b0, cur} - {1'b0, stp};
            reached = n[D_WIDTH] || (n[D_WIDTH-1:0] <= tgt);
        end else begin
            n       = {1'b0, cur} + {1'b0, stp};
            reached = (n >= {1'b0, tgt});
        end
        return {reached, reached ? tgt : n[D_WIDTH-1:0]};
    endfunction

    assign w_tgt     = r_tgt_stop ? r_lo_stop  : r_lo_start;
    assign w_tgt_rev = r_tgt_stop ? r_lo_start : r_lo_stop;
    assign w_last    = (r_cnt == r_dwell - DW_ONE);
    assign w_fwd     = step_toward(r_incr, r_dir_dn, r_step, w_tgt);
    // On a loop reversal the endpoint is not repeated: the first step toward the other end happens at once.
    assign w_rev     = step_toward(r_incr, ~r_dir_dn, r_step, w_tgt_rev);

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_dwell_nxt    = r_dwell;
        w_step_nxt     = r_step;
        w_lo_start_nxt = r_lo_start;
        w_lo_stop_nxt  = r_lo_stop;
        w_tgt_stop_nxt = r_tgt_stop;
        w_dir_dn_nxt   = r_dir_dn;
        w_incr_nxt     = r_incr;
        w_offset_nxt   = r_offset;
        case (r_state)
            IDLE: begin
                if (s.start && !s.abort) begin
                    w_lo_start_nxt = s.incr_start;
                    w_lo_stop_nxt  = s.incr_stop;
                    w_step_nxt     = (s.step == '0) ? D_ONE : s.step;
                    w_dwell_nxt    = (s.dwell == '0) ? DW_ONE : s.dwell;
                    w_tgt_stop_nxt = 1'b1;
                    w_dir_dn_nxt   = (s.incr_start > s.incr_stop);
                    w_incr_nxt     = s.incr_start;
                    w_offset_nxt   = s.offset_in;
                    w_cnt_nxt      = '0;
                    w_state_nxt    = (s.incr_start == s.incr_stop) ? HOLD : SWEEP;
                end
            end
            SWEEP: begin
                if (s.abort) begin
                    w_state_nxt = IDLE;
                end else if (w_last) begin
                    w_cnt_nxt  = '0;
                    w_incr_nxt = w_fwd[D_WIDTH-1:0];
                    if (w_fwd[D_WIDTH]) w_state_nxt = HOLD;
                end else begin
                    w_cnt_nxt = r_cnt + DW_ONE;
                end
            end
            HOLD: begin
                if (s.abort) begin
                    w_state_nxt = IDLE;
                end else if (w_last) begin
                    w_cnt_nxt = '0;
                    if (s.loop) begin
                        w_tgt_stop_nxt = ~r_tgt_stop;
                        w_dir_dn_nxt   = ~r_dir_dn;
                        w_incr_nxt     = w_rev[D_WIDTH-1:0];
                        w_state_nxt    = w_rev[D_WIDTH] ? HOLD : SWEEP;
                    end else begin
                        w_state_nxt = DONE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + DW_ONE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_dwell    <= DW_ONE;
            r_step     <= D_ONE;
            r_lo_start <= '0;
            r_lo_stop  <= '0;
            r_tgt_stop <= 1'b1;
            r_dir_dn   <= 1'b0;
            r_incr     <= '0;
            r_offset   <= '0;
            r_en       <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_dwell    <= w_dwell_nxt;
            r_step     <= w_step_nxt;
            r_lo_start <= w_lo_start_nxt;
            r_lo_stop  <= w_lo_stop_nxt;
            r_tgt_stop <= w_tgt_stop_nxt;
            r_dir_dn   <= w_dir_dn_nxt;
            r_incr     <= w_incr_nxt;
            r_offset   <= w_offset_nxt;
            r_en       <= (w_state_nxt == SWEEP) || (w_state_nxt == HOLD);
            r_busy     <= (w_state_nxt == SWEEP) || (w_state_nxt == HOLD);
            r_done     <= (w_state_nxt == DONE);
        end
    end

    assign s.en     = r_en;
    assign s.incr   = r_incr;
    assign s.offset = r_offset;
    assign s.busy   = r_busy;
    assign s.done   = r_done;
endmodule
